// File: rtl/percep_wght_arb.sv
// Weight-memory arbiter for a perceptron: alternates ties between inference reads and training
// writes, granting each a fixed ATTR-beat burst over a single-port weight memory.
module percep_wght_arb #(
  parameter int ATTR          = 5,
  parameter int MEM_ADDR_WGHT = 3,
  parameter int FP_WIDTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_req,
  output logic                     rd_gnt,
  output logic                     rd_vld,
  output logic [MEM_ADDR_WGHT-1:0] rd_idx,
  output logic [FP_WIDTH-1:0]      rd_data,
  output logic                     rd_done,
  input  logic                     wr_req,
  output logic                     wr_gnt,
  output logic [MEM_ADDR_WGHT-1:0] wr_idx,
  input  logic [FP_WIDTH-1:0]      wr_data,
  output logic                     wr_done,
  output logic                     busy,
  output logic                     mem_cs,
  output logic                     mem_we,
  output logic                     mem_oe,
  output logic [MEM_ADDR_WGHT-1:0] mem_addr,
  output logic [FP_WIDTH-1:0]      mem_din,
  input  logic [FP_WIDTH-1:0]      mem_dout
);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

  localparam logic [MEM_ADDR_WGHT-1:0] LAST_BEAT = MEM_ADDR_WGHT'(ATTR - 1);

  state_t                   state, state_nxt;
  logic [MEM_ADDR_WGHT-1:0] cnt, cnt_nxt;
  logic                     last_gnt, last_gnt_nxt;  // side of the most recent grant: 0=read, 1=write

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    last_gnt_nxt = last_gnt;
    rd_gnt       = 1'b0;
    wr_gnt       = 1'b0;
    rd_done      = 1'b0;
    wr_done      = 1'b0;
    mem_cs       = 1'b0;
    mem_we       = 1'b0;
    mem_oe       = 1'b0;
    mem_addr     = '0;
    mem_din      = '0;
    wr_idx       = '0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        // Grants are held off while reset is asserted so all outputs read zero.
        if (rst_n) begin
          if (rd_req && (!wr_req || last_gnt)) begin
            rd_gnt       = 1'b1;
            last_gnt_nxt = 1'b0;
            state_nxt    = RD_BURST;
          end else if (wr_req) begin
            wr_gnt       = 1'b1;
            last_gnt_nxt = 1'b1;
            state_nxt    = WR_BURST;
          end
        end
      end
      RD_BURST: begin
        mem_cs   = 1'b1;
        mem_oe   = 1'b1;
        mem_addr = cnt;
        cnt_nxt  = cnt + 1'b1;
        if (cnt == LAST_BEAT) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end
      end
      WR_BURST: begin
        mem_cs   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = cnt;
        wr_idx   = cnt;
        mem_din  = wr_data;
        cnt_nxt  = cnt + 1'b1;
        if (cnt == LAST_BEAT) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end
      end
      DONE: begin
        rd_done   = !last_gnt;
        wr_done   = last_gnt;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Read data is registered: valid the cycle after its address was presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld  <= 1'b0;
      rd_idx  <= '0;
      rd_data <= '0;
    end else begin
      rd_vld <= (state == RD_BURST);
      if (state == RD_BURST) begin
        rd_idx  <= cnt;
        rd_data <= mem_dout;
      end
    end
  end

endmodule

// File: tb/tb_percep_wght_arb.sv
// Self-checking bench for percep_wght_arb: burst-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized request traffic.
module tb_percep_wght_arb;

  localparam int ATTR = 5;
  localparam int AW   = 3;
  localparam int FW   = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_req, wr_req;
  logic          rd_gnt, rd_vld, rd_done, wr_gnt, wr_done, busy;
  logic [AW-1:0] rd_idx, wr_idx, mem_addr;
  logic [FW-1:0] rd_data, wr_data, mem_din, mem_dout;
  logic          mem_cs, mem_we, mem_oe;

  logic [FW-1:0] tb_mem  [0:7];
  logic [FW-1:0] ld_vals [0:7];
  logic [FW-1:0] wr_pat  [0:7];
  logic          ld_en;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  percep_wght_arb #(.ATTR(ATTR), .MEM_ADDR_WGHT(AW), .FP_WIDTH(FW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_idx(rd_idx),
    .rd_data(rd_data), .rd_done(rd_done),
    .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_idx(wr_idx), .wr_data(wr_data),
    .wr_done(wr_done), .busy(busy),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Weight memory and write-side requester fixture.
  assign mem_dout = tb_mem[mem_addr];
  assign wr_data  = wr_pat[wr_idx];

  always @(posedge clk) begin
    if (ld_en) begin
      for (int i = 0; i < 8; i++) tb_mem[i] <= ld_vals[i];
    end else if (mem_cs && mem_we) begin
      tb_mem[mem_addr] <= mem_din;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Event logs written by the monitor, inspected by the directed scenarios.
  typedef struct {int cyc; bit wr;} ev_t;
  typedef struct {int cyc; int idx; int data;} rv_t;
  ev_t gnt_log[$];
  ev_t done_log[$];
  rv_t rdv_log[$];
  int  cyc = 0;
  logic rd_done_seen = 1'b0, wr_done_seen = 1'b0;

  // Burst-level reference: each granted burst spans ATTR+2 cycles counted from its grant cycle.
  logic [FW-1:0] model_mem [0:7];
  bit  m_active = 1'b0, m_wr = 1'b0, m_last = 1'b1;
  int  m_k = 0;

  always @(negedge clk) begin
    int e_rg, e_wg, e_busy, e_cs, e_we, e_oe, e_addr, e_din, e_widx, e_vld, e_idx, e_data, e_rd, e_wd;
    cyc++;
    rd_done_seen = rd_done;
    wr_done_seen = wr_done;
    if (rd_gnt)  gnt_log.push_back('{cyc, 1'b0});
    if (wr_gnt)  gnt_log.push_back('{cyc, 1'b1});
    if (rd_done) done_log.push_back('{cyc, 1'b0});
    if (wr_done) done_log.push_back('{cyc, 1'b1});
    if (rd_vld)  rdv_log.push_back('{cyc, int'(rd_idx), int'(rd_data)});

    {e_rg, e_wg, e_busy, e_cs, e_we, e_oe, e_addr, e_din, e_widx} = '0;
    {e_vld, e_idx, e_data, e_rd, e_wd} = '0;
    if (!rst_n) begin
      m_active = 1'b0;
      m_last   = 1'b1;
    end else if (!m_active) begin
      if (rd_req && (!wr_req || m_last)) begin
        m_active = 1'b1; m_wr = 1'b0; e_rg = 1;
      end else if (wr_req) begin
        m_active = 1'b1; m_wr = 1'b1; e_wg = 1;
      end
      if (m_active) begin
        m_k    = 0;
        m_last = m_wr;
      end
    end else begin
      e_busy = 1;
      if (m_k <= ATTR) begin
        e_cs = 1; e_addr = m_k - 1;
        if (m_wr) begin
          e_we = 1; e_widx = m_k - 1; e_din = int'(wr_data);
        end else begin
          e_oe = 1;
        end
      end
      if (!m_wr && m_k >= 2) begin
        e_vld = 1; e_idx = m_k - 2; e_data = int'(model_mem[m_k - 2]);
      end
      if (m_k == ATTR + 1) begin
        e_rd = m_wr ? 0 : 1;
        e_wd = m_wr ? 1 : 0;
      end
    end

    check("rd_gnt",   32'(rd_gnt),   e_rg);
    check("wr_gnt",   32'(wr_gnt),   e_wg);
    check("busy",     32'(busy),     e_busy);
    check("mem_cs",   32'(mem_cs),   e_cs);
    check("mem_we",   32'(mem_we),   e_we);
    check("mem_oe",   32'(mem_oe),   e_oe);
    check("mem_addr", 32'(mem_addr), e_addr);
    check("mem_din",  32'(mem_din),  e_din);
    check("wr_idx",   32'(wr_idx),   e_widx);
    check("rd_vld",   32'(rd_vld),   e_vld);
    check("rd_done",  32'(rd_done),  e_rd);
    check("wr_done",  32'(wr_done),  e_wd);
    if (!rst_n || e_vld != 0) begin
      check("rd_idx",  32'(rd_idx),  e_idx);
      check("rd_data", 32'(rd_data), e_data);
    end
    check("we_oe_exclusive", 32'(mem_we & mem_oe), 0);
    check("gnt_exclusive",   32'(rd_gnt & wr_gnt), 0);

    if (rst_n && m_active) begin
      if (m_wr && m_k >= 1 && m_k <= ATTR) model_mem[m_k - 1] = wr_data;
      m_k++;
      if (m_k > ATTR + 1) m_active = 1'b0;
    end
    if (ld_en) begin
      for (int i = 0; i < 8; i++) model_mem[i] = ld_vals[i];
    end
  end

  // Requesters drop their request on the edge following their done pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rd_done_seen) rd_req = 1'b0;
    if (wr_done_seen) wr_req = 1'b0;
  endtask

  task automatic run_until_quiet(input int budget);
    int t = 0;
    while ((rd_req || wr_req || busy) && t < budget) begin
      tick();
      t++;
    end
    check("quiet_timeout", 32'(rd_req | wr_req | busy), 0);
  endtask

  task automatic load_mem();
    ld_en = 1'b1;
    tick();
    ld_en = 1'b0;
  endtask

  initial begin
    int g0, r0, d0, n, r1, d1;
    rst_n  = 1'b0;
    rd_req = 1'b1;
    wr_req = 1'b1;
    ld_en  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_pat[i]  = '0;
      ld_vals[i] = FW'(i + 1);
    end
    tick();
    tick();
    check("rst_busy",    32'(busy),    0);
    check("rst_rd_gnt",  32'(rd_gnt),  0);
    check("rst_wr_gnt",  32'(wr_gnt),  0);
    check("rst_rd_vld",  32'(rd_vld),  0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_mem_cs",  32'(mem_cs),  0);
    rd_req = 1'b0;
    wr_req = 1'b0;
    tick();
    rst_n = 1'b1;
    load_mem();

    // Tie after reset: read, write, then read again, with burst timing pinned to literals.
    for (int i = 0; i < 8; i++) wr_pat[i] = 16'h0100 + FW'(i);
    g0 = gnt_log.size(); r0 = rdv_log.size(); d0 = done_log.size();
    rd_req = 1'b1;
    wr_req = 1'b1;
    for (int t = 0; t < 40 && wr_req; t++) tick();
    check("tie_wr_dropped", 32'(wr_req), 0);
    rd_req = 1'b1;
    wr_req = 1'b1;
    run_until_quiet(60);
    check("tie_gnt_count", gnt_log.size() - g0, 4);
    check("tie_rdv_count", rdv_log.size() - r0, 10);
    check("tie_done_count", done_log.size() - d0, 4);
    if (gnt_log.size() >= g0 + 4 && rdv_log.size() >= r0 + 10 && done_log.size() >= d0 + 2) begin
      n = gnt_log[g0].cyc;
      check("tie_first_is_rd",  32'(gnt_log[g0].wr), 0);
      check("tie_second_is_wr", 32'(gnt_log[g0 + 1].wr), 1);
      check("tie_third_is_rd",  32'(gnt_log[g0 + 2].wr), 0);
      check("wr_gnt_cycle",  gnt_log[g0 + 1].cyc - n, 7);
      check("rd2_gnt_cycle", gnt_log[g0 + 2].cyc - n, 14);
      check("rd_done_cycle", done_log[d0].cyc - n, 6);
      check("wr_done_cycle", done_log[d0 + 1].cyc - n, 13);
      for (int i = 0; i < ATTR; i++) begin
        check("rd1_vld_cycle", rdv_log[r0 + i].cyc - n, 2 + i);
        check("rd1_idx",  rdv_log[r0 + i].idx, i);
        check("rd1_data", rdv_log[r0 + i].data, i + 1);
        check("rd2_data", rdv_log[r0 + 5 + i].data, 32'h0100 + i);
      end
    end

    // Read request dropped after two beats still yields a full burst.
    r1 = rdv_log.size(); d1 = done_log.size();
    rd_req = 1'b1;
    tick(); tick(); tick();
    rd_req = 1'b0;
    run_until_quiet(30);
    check("drop_rdv_count", rdv_log.size() - r1, 5);
    check("drop_done_count", done_log.size() - d1, 1);
    if (rdv_log.size() >= r1 + 5) check("drop_last_data", rdv_log[r1 + 4].data, 32'h0104);

    // Reset during write beat 2 aborts at once; beats 0 and 1 already committed.
    for (int i = 0; i < 8; i++) wr_pat[i] = 16'hA000 + FW'(i);
    d1 = done_log.size();
    wr_req = 1'b1;
    tick(); tick(); tick();
    #2;
    rst_n  = 1'b0;
    wr_req = 1'b0;
    #1;
    check("abort_busy",   32'(busy),   0);
    check("abort_mem_we", 32'(mem_we), 0);
    check("abort_mem_cs", 32'(mem_cs), 0);
    check("abort_wr_idx", 32'(wr_idx), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check("abort_w0", 32'(tb_mem[0]), 32'hA000);
    check("abort_w1", 32'(tb_mem[1]), 32'hA001);
    check("abort_w2", 32'(tb_mem[2]), 32'h0102);
    check("abort_w3", 32'(tb_mem[3]), 32'h0103);
    check("abort_w4", 32'(tb_mem[4]), 32'h0104);
    check("abort_no_done", done_log.size() - d1, 0);

    // Randomized request traffic against the reference model.
    for (int round = 0; round < 4; round++) begin
      for (int i = 0; i < 8; i++) ld_vals[i] = FW'($urandom);
      load_mem();
      for (int t = 0; t < 150; t++) begin
        tick();
        if (!rd_req && $urandom_range(3) == 0) rd_req = 1'b1;
        if (!wr_req && $urandom_range(3) == 0) wr_req = 1'b1;
        if (rd_req && busy && $urandom_range(15) == 0) rd_req = 1'b0;
        if (wr_req && busy && $urandom_range(15) == 0) wr_req = 1'b0;
        if ($urandom_range(3) == 0) wr_pat[$urandom_range(7)] = FW'($urandom);
      end
      run_until_quiet(40);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/percep_wght_arb.md
PERCEP_WGHT_ARB -- requirements
Module: percep_wght_arb

Interface
REQ-001 SHALL have parameter ATTR, default 5, number of weights per burst (w0..w4); ATTR <= 2**MEM_ADDR_WGHT.
REQ-002 SHALL have parameter MEM_ADDR_WGHT, default 3, weight memory address width.
REQ-003 SHALL have parameter FP_WIDTH, default 16, fixed-point data width.
REQ-004 SHALL have ports, one clock, reset asynchronous active-low:
 clk       input   1              clock, rising edge
 rst_n     input   1              asynchronous active-low reset
 rd_req    input   1              inference read requester, held high until rd_done
 rd_gnt    output  1              1-cycle pulse, read burst granted
 rd_vld    output  1              rd_data/rd_idx valid
 rd_idx    output  MEM_ADDR_WGHT  weight index of rd_data
 rd_data   output  FP_WIDTH       registered weight value
 rd_done   output  1              1-cycle pulse, last read beat delivered
 wr_req    input   1              training-update requester, held high until wr_done
 wr_gnt    output  1              1-cycle pulse, write burst granted
 wr_idx    output  MEM_ADDR_WGHT  index requester must drive on wr_data this cycle
 wr_data   input   FP_WIDTH       updated weight, combinationally consumed
 wr_done   output  1              1-cycle pulse, write burst complete
 busy      output  1              high in any state other than IDLE
 mem_cs    output  1              memory chip select
 mem_we    output  1              memory write enable
 mem_oe    output  1              memory read enable
 mem_addr  output  MEM_ADDR_WGHT  memory address
 mem_din   output  FP_WIDTH       memory write data
 mem_dout  input   FP_WIDTH       memory combinational read data

Function
REQ-005 SHALL implement FSM states IDLE, RD_BURST, WR_BURST, DONE.
REQ-006 IDLE: only rd_req -> RD_BURST; only wr_req -> WR_BURST; both -> grant side opposite to last_gnt; neither -> stay.
REQ-007 Granting SHALL pulse rd_gnt/wr_gnt in the IDLE cycle and update last_gnt (1-bit, 0=read, 1=write).
REQ-008 Beat counter cnt SHALL reset to 0 on entry to each burst, increment once per cycle, burst lasts exactly ATTR cycles, addresses 0..ATTR-1 ascending.
REQ-009 RD_BURST: mem_cs=1, mem_oe=1, mem_we=0, mem_addr=cnt; at each edge rd_data<=mem_dout, rd_idx<=cnt, rd_vld<=1 (data valid one cycle after address).
REQ-010 WR_BURST: mem_cs=1, mem_we=1, mem_oe=0, mem_addr=cnt, wr_idx=cnt, mem_din=wr_data; write commits at the edge ending each beat.
REQ-011 After beat cnt=ATTR-1, FSM SHALL enter DONE for exactly one cycle, then IDLE.
REQ-012 In DONE: rd_done=1 with final rd_vld (idx ATTR-1) if burst was read; wr_done=1 if write; memory outputs idle.
REQ-013 Outside bursts: mem_cs=mem_we=mem_oe=0, mem_addr=0, mem_din=0, wr_idx=0; rd_vld=0 except the cycle after each read beat.
REQ-014 Requester deassertion of req mid-burst SHALL be ignored; burst always completes all ATTR beats.
REQ-015 Requester drops req on the edge after done; IDLE following DONE SHALL arbitrate normally (back-to-back bursts: min 2-cycle gap, DONE+IDLE).
REQ-016 Read latency: rd_req sampled in IDLE at cycle N -> rd_gnt at N, first rd_vld at N+2, rd_done at N+ATTR+1.
REQ-017 mem_we and mem_oe SHALL never be high simultaneously; rd_gnt and wr_gnt never high simultaneously.

Reset
REQ-018 rst_n low SHALL asynchronously force state=IDLE, cnt=0, last_gnt=1 (read wins first tie), all outputs 0, rd_data=0.
REQ-019 Reset mid-burst SHALL abort immediately; weights already written remain, no done pulse issued.

Verification
REQ-020 Memory preloaded w0..w4=0x0001..0x0005, rd_req at cycle N -> rd_gnt N, rd_vld N+2..N+6 data 0x0001..0x0005 idx 0..4, rd_done at N+6.
REQ-021 wr_req with wr_data=0x0100+wr_idx -> 5 write beats addr 0..4, wr_done after; subsequent read returns 0x0100..0x0104.
REQ-022 rd_req and wr_req asserted same cycle after reset -> read granted first, write granted in IDLE after read DONE, then next tie grants read again.
REQ-023 rd_req dropped after 2 beats -> all 5 beats and rd_done still produced.
REQ-024 rst_n pulsed low during write beat 2 -> outputs 0 at once, mem w0,w1 updated, w2..w4 unchanged, no wr_done.
REQ-025 Continuous check every cycle: never mem_we&mem_oe, never both grants, busy==(state!=IDLE).
